// File: rtl/t02_regfile_dumper.sv
// rtl/t02_regfile_dumper.sv - streams a register file out word by word with a running XOR checksum
// READ samples the combinational read port, SEND offers the word until it is accepted.
module t02_regfile_dumper #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              start,
    input  logic              abort,
    output logic [4:0]        rf_read_index,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t            r_state;
    logic [4:0]        r_idx;
    logic [DATA_W-1:0] r_out_data;
    logic [4:0]        r_out_index;
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_idx       <= 5'd0;
            r_out_data  <= '0;
            r_out_index <= 5'd0;
            r_checksum  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_idx      <= 5'd0;
                        r_checksum <= '0;
                        r_state    <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_out_data  <= rf_read_data;
                        r_out_index <= r_idx;
                        r_state     <= SEND;
                    end
                end
                SEND: begin
                    // abort wins over a handshake landing on the same edge
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (out_ready) begin
                        r_checksum <= r_checksum ^ r_out_data;
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= READ;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rf_read_index = r_idx;
    assign out_data      = r_out_data;
    assign out_index     = r_out_index;
    assign checksum      = r_checksum;
    assign out_valid     = (r_state == SEND);
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);

endmodule

// File: tb/tb_t02_regfile_dumper.sv
// tb/tb_t02_regfile_dumper.sv - randomized self-checking bench for t02_regfile_dumper
module tb_t02_regfile_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRST;
    logic [1:0]  start_v, abort_v, ready_v;
    logic [31:0] rf [32];

    logic [4:0]  a_rd_idx, b_rd_idx, a_out_index, b_out_index;
    logic [31:0] a_rd_data, b_rd_data, a_out_data, b_out_data, a_ck, b_ck;
    logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;

    assign a_rd_data = rf[a_rd_idx];
    assign b_rd_data = rf[b_rd_idx];

    t02_regfile_dumper #(.NUM_REGS(32), .DATA_W(32)) u_dut_a (
        .clk(clk), .nRST(nRST), .start(start_v[0]), .abort(abort_v[0]),
        .rf_read_index(a_rd_idx), .rf_read_data(a_rd_data),
        .out_data(a_out_data), .out_index(a_out_index), .out_valid(a_valid),
        .out_ready(ready_v[0]), .busy(a_busy), .done(a_done), .checksum(a_ck)
    );

    t02_regfile_dumper #(.NUM_REGS(4), .DATA_W(32)) u_dut_b (
        .clk(clk), .nRST(nRST), .start(start_v[1]), .abort(abort_v[1]),
        .rf_read_index(b_rd_idx), .rf_read_data(b_rd_data),
        .out_data(b_out_data), .out_index(b_out_index), .out_valid(b_valid),
        .out_ready(ready_v[1]), .busy(b_busy), .done(b_done), .checksum(b_ck)
    );

    int sel = 0;
    wire [4:0]  m_rd_idx = (sel != 0) ? b_rd_idx    : a_rd_idx;
    wire [4:0]  m_oidx   = (sel != 0) ? b_out_index : a_out_index;
    wire [31:0] m_odata  = (sel != 0) ? b_out_data  : a_out_data;
    wire [31:0] m_ck     = (sel != 0) ? b_ck        : a_ck;
    wire        m_valid  = (sel != 0) ? b_valid     : a_valid;
    wire        m_busy   = (sel != 0) ? b_busy      : a_busy;
    wire        m_done   = (sel != 0) ? b_done      : a_done;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_odata"}, m_odata, 32'd0);
        chk({tag, "_oidx"}, m_oidx, 32'd0);
        chk({tag, "_ck"}, m_ck, 32'd0);
        chk({tag, "_valid"}, m_valid, 32'd0);
        chk({tag, "_busy"}, m_busy, 32'd0);
        chk({tag, "_done"}, m_done, 32'd0);
        chk({tag, "_rdidx"}, m_rd_idx, 32'd0);
    endtask

    // Reference: the accepted stream must be rf[0..n-1] in order, checksum the XOR of
    // what was accepted, and each accepted word is followed by one non-valid cycle.
    task automatic run_dump(input int n, input int rdy_pct, input int abort_idx,
                            input int stall_idx, input int stall_len, input int restart_idx);
        int          exp_idx  = 0;
        logic [31:0] exp_ck   = 32'd0;
        int          cyc      = 0;
        int          stalled  = 0;
        bit          last_acc = 1'b0;
        bit          prev_hs  = 1'b0;
        bit          hs;
        start_v[sel] = 1'b1;
        step();
        start_v[sel] = 1'b0;
        while (cyc < 1000) begin
            chk("busy", m_busy, 1);
            chk("done", m_done, {31'd0, last_acc});
            chk("rd_idx", m_rd_idx, exp_idx);
            chk("cksum", m_ck, exp_ck);
            start_v[sel] = 1'b0;
            if (last_acc) begin
                if (rdy_pct == 100 && stall_len == 0)
                    chk("latency", cyc, 2 * n);
                ready_v[sel] = 1'b0;
                step();
                chk("post_busy", m_busy, 0);
                chk("post_done", m_done, 0);
                chk("post_rdidx", m_rd_idx, n - 1);
                chk("post_ck", m_ck, exp_ck);
                return;
            end
            if (prev_hs)
                chk("valid_gap", m_valid, 0);
            if (m_valid) begin
                chk("out_index", m_oidx, exp_idx);
                chk("out_data", m_odata, rf[exp_idx]);
            end
            if (m_valid && exp_idx == stall_idx && stalled < stall_len) begin
                ready_v[sel] = 1'b0;
                stalled++;
            end else begin
                ready_v[sel] = ($urandom_range(99) < rdy_pct) ? 1'b1 : 1'b0;
            end
            if (m_valid && exp_idx == restart_idx)
                start_v[sel] = 1'b1;
            if (m_valid && exp_idx == abort_idx) begin
                abort_v[sel] = 1'b1;
                ready_v[sel] = 1'b1;
                step();
                abort_v[sel] = 1'b0;
                ready_v[sel] = 1'b0;
                chk("abort_busy", m_busy, 0);
                chk("abort_valid", m_valid, 0);
                chk("abort_done", m_done, 0);
                chk("abort_ck", m_ck, exp_ck);
                return;
            end
            hs = m_valid && ready_v[sel];
            if (hs) begin
                exp_ck ^= rf[exp_idx];
                if (exp_idx == n - 1) last_acc = 1'b1;
                else exp_idx++;
            end
            prev_hs = hs;
            step();
            cyc++;
        end
        chk("timeout", 0, 1);
    endtask

    initial begin
        int cnt;
        nRST    = 1'b0;
        start_v = 2'b00;
        abort_v = 2'b00;
        ready_v = 2'b00;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11111111;
        step();
        step();
        chk_all_zero("reset_a");
        sel = 1;
        chk_all_zero("reset_b");
        sel = 0;
        nRST = 1'b1;
        step();
        chk("idle_busy", m_busy, 0);

        run_dump(32, 100, -1, -1, 0, -1);
        run_dump(32, 100, -1, 7, 5, -1);
        run_dump(32, 100, 3, -1, 0, -1);
        chk("abort_ck_const", m_ck, 32'h33333333);
        run_dump(32, 100, -1, -1, 0, 5);

        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("start_abort_idle", m_busy, 0);
        step();
        chk("start_abort_idle2", m_busy, 0);

        // reset while in READ at index 10
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        cnt = 0;
        while (!(m_busy && !m_valid && m_rd_idx == 5'd10) && cnt < 200) begin
            step();
            cnt++;
        end
        chk("reach_idx10", m_rd_idx, 10);
        #2 nRST = 1'b0;
        #1 chk_all_zero("async_rst");
        step();
        nRST = 1'b1;
        ready_v[0] = 1'b0;
        step();
        step();
        chk("rst_wait_idle", m_busy, 0);
        run_dump(32, 100, -1, -1, 0, -1);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            sel = 0;
            run_dump(32, 60, (k == 2) ? int'($urandom_range(31)) : -1, -1, 0, -1);
            step();
            sel = 1;
            run_dump(4, (k == 0) ? 100 : 50, -1, -1, 0, (k == 3) ? 1 : -1);
            step();
        end
        sel = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/t02_regfile_dumper.md
T02_REGFILE_DUMPER -- requirements
Module: t02_regfile_dumper

Interface
REQ-001 Parameter NUM_REGS, default 32, number of registers streamed per dump (2..32).
REQ-002 Parameter DATA_W, default 32, register and output word width.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 nRST  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
REQ-006 abort  input  1  terminates any dump in progress.
REQ-007 rf_read_index  output  5  read-port index driven into the register file.
REQ-008 rf_read_data  input  DATA_W  combinational read data returned for rf_read_index in the same cycle.
REQ-009 out_data  output  DATA_W  register word being offered.
REQ-010 out_index  output  5  register index associated with out_data.
REQ-011 out_valid  output  1  out_data/out_index are valid.
REQ-012 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the final word is accepted.
REQ-015 checksum  output  DATA_W  running XOR of all accepted words in the current or most recent dump.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, READ, SEND, DONE.
REQ-017 IDLE: on start=1 and abort=0, clear idx to 0, clear checksum to 0, go to READ.
REQ-018 READ (one cycle): drive rf_read_index=idx, register rf_read_data into out_data and idx into out_index, go to SEND.
REQ-019 SEND: out_valid=1; out_data/out_index SHALL hold stable until the handshake.
REQ-020 Handshake = out_valid & out_ready on a rising edge; on it, checksum <= checksum XOR out_data.
REQ-021 On handshake with idx < NUM_REGS-1: idx <= idx+1, go to READ.
REQ-022 On handshake with idx == NUM_REGS-1: go to DONE; idx is not incremented (no wrap).
REQ-023 DONE: done=1 for exactly one cycle, then go to IDLE; checksum holds its final value until the next start.
REQ-024 Throughput: at most one word per 2 cycles; with out_ready tied high, a full dump takes 2*NUM_REGS cycles from the READ entry to DONE entry.
REQ-025 rf_read_index SHALL equal idx in all states (0 in IDLE after reset).
REQ-026 abort=1 in READ, SEND or DONE: next state IDLE, out_valid low, no done pulse, no checksum update even if out_ready=1 in the same cycle; abort has priority over the handshake.
REQ-027 start and abort both high in IDLE: remain in IDLE.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 Register 0 SHALL be streamed as whatever rf_read_data returns (no forced zero in this block).
REQ-030 Outputs out_valid, busy, done SHALL be decoded from the registered state only (no combinational path from inputs).

Reset
REQ-031 nRST low SHALL immediately force state IDLE, idx=0, out_data=0, out_index=0, checksum=0, out_valid=0, busy=0, done=0, rf_read_index=0.
REQ-032 Reset asserted mid-dump SHALL discard the dump; after release the block waits in IDLE for a new start.

Verification
REQ-033 Regfile model with reg[i]=i*0x11111111 (i=0..31), out_ready=1, pulse start -> 32 words index 0..31 in order, done pulses 64 cycles after READ entry, checksum = XOR of all 32 values.
REQ-034 Same model, out_ready low for 5 cycles at index 7 -> out_valid held high, out_data=0x77777777 and out_index=7 stable for all 5 cycles, single acceptance.
REQ-035 abort asserted in SEND at index 3 with out_ready=1 -> only words 0..2 accepted, checksum=0x00000000^0x11111111^0x22222222=0x33333333, no done, busy low next cycle.
REQ-036 nRST pulsed low in READ at index 10 -> all outputs 0 asynchronously; later start restarts from index 0 with checksum cleared.
REQ-037 start pulsed again at index 5 during a dump, and start+abort together in IDLE -> no restart, no state change; dump completes normally.
REQ-038 NUM_REGS=4 -> exactly 4 words, done after index 3, idx stays 3 (no wrap to 0 before IDLE).
